add_disp_ctrl: RTL and testbench

//  Shares one 4-bit adder + BCD + two-digit seven-segment display path between two requesters (A, B).

---
 rtl/add_disp_pkg.sv | 37 +++
 rtl/add_disp_seg_decode.sv | 32 +++
 rtl/add_disp_ctrl.sv | 162 ++++++++++++++++
 tb/tb_add_disp_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_disp_pkg
// Brief    : Shared types and constants for the adder/BCD/display controller.
// Revision : 1.0
// ============================================================================
package add_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam int CONV_ITERS = 5;

    function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_disp_seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : add_disp_seg_decode
// Brief    : Combinational BCD digit to seven-segment pattern decoder.
// Revision : 1.0
// ============================================================================
module add_disp_seg_decode
    import add_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/add_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add_disp_ctrl
// Brief    : Two-requester shared 4-bit adder, serial BCD conversion and
//            multiplexed two-digit seven-segment display.
//            Option ADD_DISP_BLANK_LZ_EN blanks a zero tens digit.
// Revision : 1.0
// ============================================================================
module add_disp_ctrl
    import add_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [3:0] a_a,
    input  logic [3:0] b_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [3:0] a_b,
    input  logic [3:0] b_b,
    output logic       ack_b,
    output logic       busy,
    output logic       sum_valid,
    output logic [4:0] sum_bin,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio_b;
    logic [3:0]  r_op_a;
    logic [3:0]  r_op_b;
    logic [4:0]  r_sum;
    logic [12:0] r_shift;
    logic [2:0]  r_iter;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;
    logic [4:0]  r_sum_bin;
    logic        r_ack_a;
    logic        r_ack_b;
    logic        r_sum_valid;
    logic [REF_W-1:0] r_ref_cnt;
    logic        r_digit_sel;

    logic        w_any_req;
    logic        w_grant_b;
    logic [12:0] w_adj;
    logic [3:0]  w_digit;
    logic [6:0]  w_seg_dec;

    assign w_any_req = req_a | req_b;
    // B wins only when alone or when the pointer favours it
    assign w_grant_b = req_b & (~req_a | r_prio_b);
    assign w_adj     = {bcd_adjust(r_shift[12:9]), bcd_adjust(r_shift[8:5]), r_shift[4:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ADD;
            ADD:     w_state_nxt = CONV;
            CONV:    if (r_iter == 3'd1) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio_b    <= 1'b0;
            r_op_a      <= 4'd0;
            r_op_b      <= 4'd0;
            r_sum       <= 5'd0;
            r_shift     <= 13'd0;
            r_iter      <= 3'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_sum_bin   <= 5'd0;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_sum_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_op_a   <= w_grant_b ? a_b : a_a;
                        r_op_b   <= w_grant_b ? b_b : b_a;
                        r_ack_a  <= ~w_grant_b;
                        r_ack_b  <= w_grant_b;
                        r_prio_b <= ~w_grant_b;
                    end
                end
                ADD: begin
                    r_sum   <= {1'b0, r_op_a} + {1'b0, r_op_b};
                    r_shift <= {8'd0, {1'b0, r_op_a} + {1'b0, r_op_b}};
                    r_iter  <= 3'(CONV_ITERS);
                end
                CONV: begin
                    r_shift <= w_adj << 1;
                    r_iter  <= r_iter - 3'd1;
                end
                DONE: begin
                    r_tens      <= r_shift[12:9];
                    r_ones      <= r_shift[8:5];
                    r_sum_bin   <= r_sum;
                    r_sum_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Display refresh runs regardless of the arithmetic sequencer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ref_cnt   <= '0;
            r_digit_sel <= 1'b0;
        end else if (r_ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            r_ref_cnt   <= '0;
            r_digit_sel <= ~r_digit_sel;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    assign w_digit = r_digit_sel ? r_tens : r_ones;

    add_disp_seg_decode u_seg_decode (
        .bcd (w_digit),
        .seg (w_seg_dec)
    );

`ifdef ADD_DISP_BLANK_LZ_EN
    assign seg = (r_digit_sel && (r_tens == 4'd0)) ? SEG_BLANK : w_seg_dec;
`else
    assign seg = w_seg_dec;
`endif

    assign an        = r_digit_sel ? 2'b01 : 2'b10;
    assign busy      = (r_state != IDLE);
    assign ack_a     = r_ack_a;
    assign ack_b     = r_ack_b;
    assign sum_valid = r_sum_valid;
    assign sum_bin   = r_sum_bin;

endmodule
`default_nettype wire

// File: tb/tb_add_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_disp_ctrl
// Brief    : Self-checking bench for add_disp_ctrl with a cycle-level model.
// Revision : 1.0
// ============================================================================
module tb_add_disp_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [3:0] a_a = 4'd0, b_a = 4'd0, a_b = 4'd0, b_b = 4'd0;
    logic       ack_a, ack_b, busy, sum_valid;
    logic [4:0] sum_bin;
    logic [6:0] seg;
    logic [1:0] an;

    add_disp_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .a_a(a_a), .b_a(b_a), .ack_a(ack_a),
        .req_b(req_b), .a_b(a_b), .b_b(b_b), .ack_b(ack_b),
        .busy(busy), .sum_valid(sum_valid), .sum_bin(sum_bin),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

`ifdef ADD_DISP_BLANK_LZ_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b1111001;
        endcase
    endfunction

    // Model: a granted transaction occupies 8 cycles; result appears at the 8th edge
    bit m_live = 0;
    int m_phase, m_pend, m_sum, m_tens, m_ones, m_ref, m_sel;
    bit m_prio_b, e_ack_a, e_ack_b, e_sv;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live = 1; m_phase = 0; m_pend = 0; m_sum = 0; m_tens = 0; m_ones = 0;
            m_ref = 0; m_sel = 0; m_prio_b = 0; e_ack_a = 0; e_ack_b = 0; e_sv = 0;
        end else if (m_live) begin
            bit wb;
            e_ack_a = 0; e_ack_b = 0; e_sv = 0;
            if (m_ref == DIV - 1) begin m_ref = 0; m_sel = 1 - m_sel; end
            else m_ref++;
            if (m_phase == 0) begin
                if (req_a || req_b) begin
                    wb = req_b && (!req_a || m_prio_b);
                    m_pend = wb ? (int'(a_b) + int'(b_b)) : (int'(a_a) + int'(b_a));
                    e_ack_a = !wb; e_ack_b = wb;
                    m_prio_b = !wb;
                    m_phase = 1;
                end
            end else if (m_phase == 7) begin
                m_sum = m_pend; m_tens = m_pend / 10; m_ones = m_pend % 10;
                e_sv = 1; m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            int es;
            if (m_sel == 1) es = (BLANK && m_tens == 0) ? 0 : seg_of(m_tens);
            else            es = seg_of(m_ones);
            check("ack_a", int'(ack_a), int'(e_ack_a));
            check("ack_b", int'(ack_b), int'(e_ack_b));
            check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
            check("sum_valid", int'(sum_valid), int'(e_sv));
            check("sum_bin", int'(sum_bin), m_sum);
            check("an", int'(an), (m_sel == 1) ? 2 'b01 : 2'b10);
            check("seg", int'(seg), es);
            check("ack_excl", int'(ack_a & ack_b), 0);
        end
    end

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst_n = 0; req_a = 0; req_b = 0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic wait_sv(input string name, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (sum_valid) return;
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_an(input string name, input logic [1:0] v);
        for (int i = 0; i < 3 * DIV + 2; i++) begin
            @(negedge clk);
            if (an == v) return;
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    int lat;
    int n_a, n_b;
    string order;

    initial begin
        // Reset values
        do_reset(2);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_sum_bin", int'(sum_bin), 0);
        check("rst_seg", int'(seg), 7'b0111111);
        check("rst_an", int'(an), 2'b10);

        // 9 + 8 from A
        @(posedge clk); #1;
        req_a = 1; a_a = 4'd9; b_a = 4'd8;
        @(posedge clk); #1;
        req_a = 0; a_a = 4'd0; b_a = 4'd0;
        @(negedge clk);
        check("t2_ack_a", int'(ack_a), 1);
        wait_sv("t2_sv", lat);
        check("t2_latency", lat, 7);
        check("t2_sum", int'(sum_bin), 17);
        wait_an("t2_an_tens", 2'b01);
        check("t2_tens_seg", int'(seg), 7'b0000110);
        wait_an("t2_an_ones", 2'b10);
        check("t2_ones_seg", int'(seg), 7'b0000111);

        // Simultaneous requests alternate A, B, A
        do_reset(2);
        @(posedge clk); #1;
        req_a = 1; req_b = 1; a_a = 4'd2; b_a = 4'd3; a_b = 4'd4; b_b = 4'd4;
        order = "";
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (ack_a) order = {order, "A"};
            if (ack_b) order = {order, "B"};
        end
        req_a = 0; req_b = 0;
        check("t3_order", (order == "ABA") ? 1 : 0, 1);
        repeat (10) @(negedge clk);

        // 15 + 15 from B: carry kept
        @(posedge clk); #1;
        req_b = 1; a_b = 4'd15; b_b = 4'd15;
        @(posedge clk); #1;
        req_b = 0;
        wait_sv("t4_sv", lat);
        check("t4_sum", int'(sum_bin), 30);
        wait_an("t4_an_tens", 2'b01);
        check("t4_tens_seg", int'(seg), 7'b1001111);
        wait_an("t4_an_ones", 2'b10);
        check("t4_ones_seg", int'(seg), 7'b0111111);

        // Reset during conversion
        @(posedge clk); #1;
        req_a = 1; a_a = 4'd7; b_a = 4'd6;
        @(posedge clk); #1;
        req_a = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("t5_busy", int'(busy), 0);
        check("t5_sum_bin", int'(sum_bin), 0);
        check("t5_seg", int'(seg), 7'b0111111);
        n_a = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sum_valid) n_a++;
        end
        check("t5_no_sv", n_a, 0);
        @(posedge clk); #1;
        req_a = 1; req_b = 1;
        @(posedge clk); #1;
        req_a = 0; req_b = 0;
        @(negedge clk);
        check("t5_ptr_a", int'(ack_a), 1);
        repeat (10) @(negedge clk);

        // Zero tens digit and refresh cadence
        do_reset(2);
        @(posedge clk); #1;
        req_a = 1; a_a = 4'd5; b_a = 4'd3;
        @(posedge clk); #1;
        req_a = 0;
        wait_sv("t6_sv", lat);
        check("t6_sum", int'(sum_bin), 8);
        wait_an("t6_an_ones", 2'b10);
        wait_an("t6_an_tens", 2'b01);
        check("t6_tens_seg", int'(seg), BLANK ? 7'b0000000 : 7'b0111111);
        n_a = 1;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (an != 2'b01) break;
            n_a++;
        end
        check("t6_slot_len", n_a, DIV);
        check("t6_ones_seg", int'(seg), 7'b1111111);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req_a = ($urandom_range(0, 3) == 0);
            req_b = ($urandom_range(0, 3) == 0);
            a_a = 4'($urandom); b_a = 4'($urandom);
            a_b = 4'($urandom); b_b = 4'($urandom);
            rst_n = ($urandom_range(0, 149) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1; req_a = 0; req_b = 0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
